fr_transmitter: RTL and testbench

FR_TRANSMITTER -- requirements
Module: fr_transmitter

---
 rtl/fr_transmitter.sv | 249 ++++++++++++++++++++++++
 tb/tb_fr_transmitter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fr_transmitter.sv
// fr_transmitter: bit-serial CAN 2.0 frame transmitter (base and extended frames).
// One SP rising edge per bus bit. Handles bit stuffing, CRC-15 and the ACK slot.
// Optional build macro FR_TX_ARB_MONITOR_EN adds an arbitration monitor.
// Ports:
//   SP        bit-time clock
//   reset     synchronous active-low reset
//   START     frame request, sampled in IDLE only
//   IDE, RTR  frame format / remote request
//   ID, DLC   identifier and data length code
//   DATA      payload, byte 0 in DATA[63:56]
//   RX        bus readback
//   TX        bus drive (1 = recessive)
//   BUSY      frame in progress
//   DONE      one-cycle end-of-transaction pulse
//   ACK_ERR   ACK slot was read recessive
//   ARB_LOST  arbitration lost (tied 0 unless the monitor macro is defined)
module fr_transmitter (
    input  logic        SP,
    input  logic        reset,
    input  logic        START,
    input  logic        IDE,
    input  logic        RTR,
    input  logic [28:0] ID,
    input  logic [3:0]  DLC,
    input  logic [63:0] DATA,
    input  logic        RX,
    output logic        TX,
    output logic        BUSY,
    output logic        DONE,
    output logic        ACK_ERR,
    output logic        ARB_LOST
);
    localparam int unsigned CNT_W = 7;
    localparam int unsigned RUN_W = 3;
    localparam int unsigned CRC_W = 15;
    localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;

    typedef enum logic [4:0] {
        S_IDLE, S_SOF, S_ID_A, S_SRR, S_IDE, S_ID_B, S_RTR, S_R1, S_R0, S_DLC,
        S_DATA, S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_IFS
    } state_t;

    // While stuff=1, TX holds a stuff bit and (state, cnt) already name the
    // next logical bit, which is sent on the following edge.
    state_t            state, state_nx, adv_state;
    logic [CNT_W-1:0]  cnt, cnt_nx, adv_cnt, field_len, data_len;
    logic              stuff, stuff_nx;
    logic [RUN_W-1:0]  run, run_nx;
    logic [CRC_W-1:0]  crc, crc_nx;
    logic              tx_nx, busy_nx, done_nx, ack_err_nx;
    logic              accept, arb_hit, stuffable, bit_nx, crc_fb;
    logic [10:0]       id_base;
    logic              ide_q, rtr_q;
    logic [28:0]       id_q;
    logic [3:0]        dlc_q;
    logic [63:0]       data_q;

    assign accept    = (state == S_IDLE) && START;
    assign stuffable = state inside {S_SOF, S_ID_A, S_SRR, S_IDE, S_ID_B, S_RTR,
                                     S_R1, S_R0, S_DLC, S_DATA, S_CRC};
`ifdef FR_TX_ARB_MONITOR_EN
    assign arb_hit = (state inside {S_ID_A, S_SRR, S_IDE, S_ID_B, S_RTR})
                     && !stuff && TX && !RX;
`else
    assign arb_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge SP) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            stuff <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            stuff <= stuff_nx;
        end
    end

    // Field length and the next logical bit position
    always_comb begin
        data_len  = rtr_q ? '0 : (dlc_q[3] ? CNT_W'(64) : CNT_W'({dlc_q[2:0], 3'b000}));
        field_len = CNT_W'(1);
        case (state)
            S_ID_A:  field_len = CNT_W'(11);
            S_ID_B:  field_len = CNT_W'(18);
            S_DLC:   field_len = CNT_W'(4);
            S_DATA:  field_len = data_len;
            S_CRC:   field_len = CNT_W'(15);
            S_EOF:   field_len = CNT_W'(7);
            S_IFS:   field_len = CNT_W'(3);
            default: field_len = CNT_W'(1);
        endcase
        adv_state = state;
        adv_cnt   = cnt + CNT_W'(1);
        if (cnt == field_len - CNT_W'(1)) begin
            adv_cnt = '0;
            case (state)
                S_SOF:     adv_state = S_ID_A;
                S_ID_A:    adv_state = ide_q ? S_SRR : S_RTR;
                S_SRR:     adv_state = S_IDE;
                S_IDE:     adv_state = ide_q ? S_ID_B : S_R0;
                S_ID_B:    adv_state = S_RTR;
                S_RTR:     adv_state = ide_q ? S_R1 : S_IDE;
                S_R1:      adv_state = S_R0;
                S_R0:      adv_state = S_DLC;
                S_DLC:     adv_state = (data_len == '0) ? S_CRC : S_DATA;
                S_DATA:    adv_state = S_CRC;
                S_CRC:     adv_state = S_CRC_DEL;
                S_CRC_DEL: adv_state = S_ACK;
                S_ACK:     adv_state = S_ACK_DEL;
                S_ACK_DEL: adv_state = S_EOF;
                S_EOF:     adv_state = S_IFS;
                default:   adv_state = S_IDLE;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stuff_nx = 1'b0;
        if (state == S_IDLE) begin
            if (START) begin
                state_nx = S_SOF;
                cnt_nx   = '0;
            end
        end else if (arb_hit) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end else if (!stuff) begin
            // after a stuff bit the held position is simply sent
            state_nx = adv_state;
            cnt_nx   = adv_cnt;
            stuff_nx = stuffable && (run == RUN_W'(5));
        end
    end

    // Value of the logical bit at the next position
    always_comb begin
        id_base = ide_q ? id_q[28:18] : id_q[10:0];
        bit_nx  = 1'b1;
        case (state_nx)
            S_SOF:   bit_nx = 1'b0;
            S_ID_A:  bit_nx = id_base[4'(CNT_W'(10) - cnt_nx)];
            S_SRR:   bit_nx = 1'b1;
            S_IDE:   bit_nx = ide_q;
            S_ID_B:  bit_nx = id_q[5'(CNT_W'(17) - cnt_nx)];
            S_RTR:   bit_nx = rtr_q;
            S_R1:    bit_nx = 1'b0;
            S_R0:    bit_nx = 1'b0;
            S_DLC:   bit_nx = dlc_q[2'(CNT_W'(3) - cnt_nx)];
            S_DATA:  bit_nx = data_q[6'(CNT_W'(63) - cnt_nx)];
            S_CRC:   bit_nx = crc[4'(CNT_W'(14) - cnt_nx)];
            default: bit_nx = 1'b1;
        endcase
        crc_fb = bit_nx ^ crc[CRC_W-1];
    end

    // Output / datapath next values
    always_comb begin
        tx_nx      = 1'b1;
        busy_nx    = BUSY;
        done_nx    = 1'b0;
        ack_err_nx = ACK_ERR;
        run_nx     = run;
        crc_nx     = crc;
        if (accept) begin
            tx_nx      = 1'b0;
            busy_nx    = 1'b1;
            ack_err_nx = 1'b0;
            run_nx     = RUN_W'(1);
            crc_nx     = '0;
        end else if (state == S_IDLE) begin
            tx_nx = 1'b1;
        end else if (arb_hit || (state_nx == S_IDLE)) begin
            busy_nx = 1'b0;
            done_nx = 1'b1;
        end else if (stuff_nx) begin
            tx_nx  = ~TX;
            run_nx = RUN_W'(1);
        end else begin
            tx_nx = bit_nx;
            if (state_nx inside {S_ID_A, S_SRR, S_IDE, S_ID_B, S_RTR, S_R1, S_R0,
                                 S_DLC, S_DATA, S_CRC})
                run_nx = (bit_nx == TX) ? run + RUN_W'(1) : RUN_W'(1);
            if (state_nx inside {S_ID_A, S_SRR, S_IDE, S_ID_B, S_RTR, S_R1, S_R0,
                                 S_DLC, S_DATA})
                crc_nx = {crc[CRC_W-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);
        end
        if ((state == S_ACK) && RX)
            ack_err_nx = 1'b1;
    end

    // Output and datapath registers
    always_ff @(posedge SP) begin
        if (!reset) begin
            TX      <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ACK_ERR <= 1'b0;
            run     <= '0;
            crc     <= '0;
            ide_q   <= 1'b0;
            rtr_q   <= 1'b0;
            id_q    <= '0;
            dlc_q   <= '0;
            data_q  <= '0;
        end else begin
            TX      <= tx_nx;
            BUSY    <= busy_nx;
            DONE    <= done_nx;
            ACK_ERR <= ack_err_nx;
            run     <= run_nx;
            crc     <= crc_nx;
            if (accept) begin
                ide_q  <= IDE;
                rtr_q  <= RTR;
                id_q   <= ID;
                dlc_q  <= DLC;
                data_q <= DATA;
            end
        end
    end

`ifdef FR_TX_ARB_MONITOR_EN
    logic arb_lost_nx;

    always_comb begin
        arb_lost_nx = ARB_LOST;
        if (accept)
            arb_lost_nx = 1'b0;
        else if (arb_hit)
            arb_lost_nx = 1'b1;
    end

    always_ff @(posedge SP) begin
        if (!reset)
            ARB_LOST <= 1'b0;
        else
            ARB_LOST <= arb_lost_nx;
    end
`else
    assign ARB_LOST = 1'b0;
`endif

endmodule

// File: tb/tb_fr_transmitter.sv
// tb_fr_transmitter: directed bench for fr_transmitter. A frame-level model
// builds the expected bus bit sequence (fields, CRC-15, stuffing, trailer) and
// every SP cycle the DUT outputs are compared against it.
module tb_fr_transmitter;
    logic        SP, reset, START, IDE, RTR, RX;
    logic [28:0] ID;
    logic [3:0]  DLC;
    logic [63:0] DATA;
    logic        TX, BUSY, DONE, ACK_ERR, ARB_LOST;

    int tests = 0;
    int fails = 0;

    logic        ub[$];     // unstuffed SOF..CRC
    logic        fb[$];     // full bus bit sequence SOF..IFS
    int          ack_idx;
    int          hdr_len;
    logic [14:0] mcrc;
    logic        e_tx, e_busy, e_done, e_ack, e_arb;

    fr_transmitter dut (
        .SP(SP), .reset(reset), .START(START), .IDE(IDE), .RTR(RTR),
        .ID(ID), .DLC(DLC), .DATA(DATA), .RX(RX), .TX(TX), .BUSY(BUSY),
        .DONE(DONE), .ACK_ERR(ACK_ERR), .ARB_LOST(ARB_LOST)
    );

    initial SP = 1'b0;
    always #5 SP = ~SP;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
        end
    endtask

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic fbk;
        fbk = b ^ c[14];
        return {c[13:0], 1'b0} ^ (fbk ? 15'h4599 : 15'h0000);
    endfunction

    task automatic build_model(input logic ide, input logic rtr, input logic [28:0] id,
                               input logic [3:0] dlc, input logic [63:0] data);
        int   nbytes;
        int   run;
        logic last;
        ub.delete();
        fb.delete();
        ub.push_back(1'b0);
        if (ide) begin
            for (int k = 28; k >= 18; k--) ub.push_back(id[k]);
            ub.push_back(1'b1);
            ub.push_back(1'b1);
            for (int k = 17; k >= 0; k--) ub.push_back(id[k]);
            ub.push_back(rtr);
            ub.push_back(1'b0);
            ub.push_back(1'b0);
        end else begin
            for (int k = 10; k >= 0; k--) ub.push_back(id[k]);
            ub.push_back(rtr);
            ub.push_back(1'b0);
            ub.push_back(1'b0);
        end
        for (int k = 3; k >= 0; k--) ub.push_back(dlc[k]);
        nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int k = 0; k < 8 * nbytes; k++) ub.push_back(data[63-k]);
        mcrc = 15'h0000;
        foreach (ub[k]) mcrc = crc_step(mcrc, ub[k]);
        hdr_len = ub.size();
        for (int k = 14; k >= 0; k--) ub.push_back(mcrc[k]);
        run  = 0;
        last = 1'b1;
        foreach (ub[k]) begin
            fb.push_back(ub[k]);
            run  = (ub[k] == last) ? run + 1 : 1;
            last = ub[k];
            if (run == 5) begin
                fb.push_back(~last);
                last = ~last;
                run  = 1;
            end
        end
        ack_idx = fb.size() + 1;
        repeat (13) fb.push_back(1'b1);   // CRC_DEL, ACK, ACK_DEL, EOF x7, IFS x3
    endtask

    task automatic set_exp(input logic t, input logic b, input logic d, input logic a, input logic l);
        e_tx = t; e_busy = b; e_done = d; e_ack = a; e_arb = l;
    endtask

    // One SP cycle, then compare every output against the expectation.
    task automatic clk_check();
        @(posedge SP);
        #1;
        chk("TX", 32'(TX), 32'(e_tx));
        chk("BUSY", 32'(BUSY), 32'(e_busy));
        chk("DONE", 32'(DONE), 32'(e_done));
        chk("ACK_ERR", 32'(ACK_ERR), 32'(e_ack));
        chk("ARB_LOST", 32'(ARB_LOST), 32'(e_arb));
    endtask

    // Drive one frame (model must already be built from the same fields).
    task automatic run_frame(input logic ide, input logic rtr, input logic [28:0] id,
                             input logic [3:0] dlc, input logic [63:0] data,
                             input logic ack_rx, input int lose_at, input int abort_at,
                             input int mid_at);
        IDE = ide; RTR = rtr; ID = id; DLC = dlc; DATA = data;
        START = 1'b1;
        RX = 1'b1;
        set_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        clk_check();
        for (int i = 0; i < fb.size(); i++) begin
            RX = fb[i];
            if (i == ack_idx) RX = ack_rx;
            if (i == lose_at) RX = 1'b0;
            if (i == mid_at) begin
                START = 1'b1;
                IDE = ~ide; RTR = ~rtr; ID = ~id; DLC = ~dlc; DATA = ~data;
            end else begin
                START = 1'b0;
            end
            if (i == abort_at) begin
                reset = 1'b0;
                set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                clk_check();
                clk_check();
                reset = 1'b1;
                RX = 1'b1;
                clk_check();
                return;
            end
`ifdef FR_TX_ARB_MONITOR_EN
            if (i == lose_at) begin
                set_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
                clk_check();
                RX = 1'b1;
                set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
                clk_check();
                return;
            end
`endif
            if (i + 1 < fb.size())
                set_exp(fb[i+1], 1'b1, 1'b0, (i >= ack_idx) ? ack_rx : 1'b0, 1'b0);
            else
                set_exp(1'b1, 1'b0, 1'b1, ack_rx, 1'b0);
            clk_check();
        end
        START = 1'b0;
        RX = 1'b1;
        set_exp(1'b1, 1'b0, 1'b0, ack_rx, 1'b0);
        clk_check();
        clk_check();
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b0; START = 1'b0; IDE = 1'b0; RTR = 1'b0; RX = 1'b1;
        ID = '0; DLC = '0; DATA = '0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        clk_check();
        clk_check();
        reset = 1'b1;
        clk_check();

        // CRC routine pinned against hand-computed values
        chk("pin_crc_1", 32'(crc_step(15'h0000, 1'b1)), 32'h4599);
        chk("pin_crc_10", 32'(crc_step(crc_step(15'h0000, 1'b1), 1'b0)), 32'h4EAB);

        // all-zero base data frame
        build_model(1'b0, 1'b0, 29'h0, 4'd0, 64'h0);
        chk("pin_zero_crc", 32'(mcrc), 32'h0);
        chk("pin_zero_len", 32'(fb.size()), 32'd53);
        v = '0;
        for (int k = 0; k < 6; k++) v = (v << 1) | 32'(fb[k]);
        chk("pin_zero_head", v, 32'b000001);
        run_frame(1'b0, 1'b0, 29'h0, 4'd0, 64'h0, 1'b0, -1, -1, -1);

        // base remote frame, ACK slot recessive
        build_model(1'b0, 1'b1, 29'h555, 4'd4, 64'hDEAD_BEEF_0000_0000);
        v = '0;
        for (int k = 0; k < 19; k++) v = (v << 1) | 32'(fb[k]);
        chk("pin_remote_head", v, 32'b0101010101011000100);
        chk("pin_remote_nodata", 32'(hdr_len), 32'd19);
        run_frame(1'b0, 1'b1, 29'h555, 4'd4, 64'hDEAD_BEEF_0000_0000, 1'b1, -1, -1, -1);

        // dominant readback on first (recessive) ID bit
        build_model(1'b0, 1'b0, 29'h400, 4'd1, 64'hA500_0000_0000_0000);
        run_frame(1'b0, 1'b0, 29'h400, 4'd1, 64'hA500_0000_0000_0000, 1'b0, 1, -1, -1);

        // extended data frame, DLC above 8
        build_model(1'b1, 1'b0, 29'h1ABCDEF0, 4'd9, 64'h0123_4567_89AB_CDEF);
        chk("pin_ext_len", 32'(hdr_len), 32'd103);
        chk("pin_ext_srr_ide", {30'd0, ub[12], ub[13]}, 32'b11);
        chk("pin_ext_dlc", {28'd0, ub[35], ub[36], ub[37], ub[38]}, 32'b1001);
        run_frame(1'b1, 1'b0, 29'h1ABCDEF0, 4'd9, 64'h0123_4567_89AB_CDEF, 1'b0, -1, -1, -1);

        // START pulsed mid-frame with different fields
        build_model(1'b0, 1'b0, 29'h123, 4'd2, 64'hFFFF_0000_0000_0000);
        run_frame(1'b0, 1'b0, 29'h123, 4'd2, 64'hFFFF_0000_0000_0000, 1'b0, -1, -1, 30);

        // reset mid-frame
        build_model(1'b0, 1'b0, 29'h2AA, 4'd3, 64'h1234_5600_0000_0000);
        run_frame(1'b0, 1'b0, 29'h2AA, 4'd3, 64'h1234_5600_0000_0000, 1'b1, -1, 25, -1);

        // recovery after abort
        build_model(1'b0, 1'b0, 29'h7F0, 4'd1, 64'hFF00_0000_0000_0000);
        run_frame(1'b0, 1'b0, 29'h7F0, 4'd1, 64'hFF00_0000_0000_0000, 1'b0, -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
